// File: rtl/efuse_aen_pulse_seq.sv
// Multi-bank eFuse AEN strobe sequencer: setup gap, op-specific AEN pulse, hold gap, with
// same-address skip, manual bypass and sticky status toward the controller register file.
module efuse_aen_pulse_seq #(
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 10,
  parameter int NUM_BANK = 2,
  parameter int BANK_W   = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_reg_mode,
  input  logic [CNT_W-1:0]    cfg_tpgm,
  input  logic [CNT_W-1:0]    cfg_trd,
  input  logic [CNT_W-1:0]    cfg_tgap,
  input  logic                sw_aen,
  input  logic [BANK_W-1:0]   sw_bank,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_pgm,
  input  logic                req_rd,
  input  logic                req_force,
  input  logic [BANK_W-1:0]   req_bank,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic [NUM_BANK-1:0] efuse_aen,
  output logic [ADDR_W-1:0]   efuse_addr,
  output logic                done_pulse,
  output logic                done_sts,
  output logic                err_sts,
  output logic                skip_sts,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    gap_q;
  logic [CNT_W-1:0]    wid_q;
  logic [BANK_W-1:0]   bank_q;
  logic                pgm_q;
  logic                last_valid_q;
  logic                pulse_on_q;
  logic [NUM_BANK-1:0] aen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                done_pulse_q;
  logic                done_sts_q;
  logic                err_sts_q;
  logic                skip_sts_q;

  logic                accept;
  logic                legal;
  logic                same_op;
  logic [CNT_W-1:0]    req_wid;

  function automatic logic [NUM_BANK-1:0] bank_onehot(input logic [BANK_W-1:0] b);
    logic [NUM_BANK-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_BANK; i++) v[i] = (b == BANK_W'(i));
    return v;
  endfunction

  assign req_ready = cfg_reg_mode & (state_q == S_IDLE) & ~done_pulse_q;
  assign accept    = req_valid & req_ready;
  assign legal     = req_pgm ^ req_rd;
  assign same_op   = last_valid_q & ~req_force & (req_bank == bank_q) &
                     (req_addr == addr_q) & (req_pgm == pgm_q);
  assign req_wid   = req_pgm ? ((cfg_tpgm == '0) ? CNT_W'(1) : cfg_tpgm)
                             : ((cfg_trd  == '0) ? CNT_W'(1) : cfg_trd);

  // NOTE: sequential state uses <= only, so every branch below reads pre-edge values;
  // blocking assignments here would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      wid_q        <= '0;
      bank_q       <= '0;
      pgm_q        <= 1'b0;
      last_valid_q <= 1'b0;
      pulse_on_q   <= 1'b0;
      aen_q        <= '0;
      addr_q       <= '0;
      done_pulse_q <= 1'b0;
      done_sts_q   <= 1'b0;
      err_sts_q    <= 1'b0;
      skip_sts_q   <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      if (!cfg_reg_mode) begin
        // Bypass aborts any op with AEN low; once idle, AEN follows sw_aen a cycle later.
        aen_q        <= (state_q == S_IDLE && sw_aen) ? bank_onehot(sw_bank) : '0;
        state_q      <= S_IDLE;
        cnt_q        <= '0;
        pulse_on_q   <= 1'b0;
        last_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            aen_q <= '0;
            if (accept) begin
              addr_q <= req_addr;
              if (!legal) begin
                err_sts_q    <= 1'b1;
                skip_sts_q   <= 1'b0;
                done_pulse_q <= 1'b1;
                done_sts_q   <= 1'b1;
                last_valid_q <= 1'b0;
              end else if (same_op) begin
                err_sts_q    <= 1'b0;
                skip_sts_q   <= 1'b1;
                done_pulse_q <= 1'b1;
                done_sts_q   <= 1'b1;
              end else begin
                err_sts_q    <= 1'b0;
                skip_sts_q   <= 1'b0;
                done_sts_q   <= 1'b0;
                last_valid_q <= 1'b1;
                bank_q       <= req_bank;
                pgm_q        <= req_pgm;
                gap_q        <= cfg_tgap;
                wid_q        <= req_wid;
                cnt_q        <= '0;
                state_q      <= (cfg_tgap != '0) ? S_SETUP : S_PULSE;
              end
            end
          end
          S_SETUP: begin
            if (cnt_q == gap_q - CNT_W'(1)) begin
              cnt_q   <= '0;
              state_q <= S_PULSE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_PULSE: begin
            // The first PULSE cycle only raises AEN; it then stays high for exactly wid_q cycles.
            if (!pulse_on_q) begin
              pulse_on_q <= 1'b1;
              aen_q      <= bank_onehot(bank_q);
            end else if (cnt_q == wid_q - CNT_W'(1)) begin
              pulse_on_q <= 1'b0;
              aen_q      <= '0;
              cnt_q      <= '0;
              if (gap_q == '0) begin
                state_q      <= S_IDLE;
                done_pulse_q <= 1'b1;
                done_sts_q   <= 1'b1;
              end else begin
                state_q <= S_HOLD;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_HOLD: begin
            aen_q <= '0;
            if (cnt_q == gap_q - CNT_W'(1)) begin
              cnt_q        <= '0;
              state_q      <= S_IDLE;
              done_pulse_q <= 1'b1;
              done_sts_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign efuse_aen  = aen_q;
  assign efuse_addr = addr_q;
  assign done_pulse = done_pulse_q;
  assign done_sts   = done_sts_q;
  assign err_sts    = err_sts_q;
  assign skip_sts   = skip_sts_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_efuse_aen_pulse_seq.sv
// Bench for efuse_aen_pulse_seq: directed scenarios plus random traffic, all compared each
// cycle against a timeline model (accept cycle + gap/width arithmetic).
module tb_efuse_aen_pulse_seq;
  localparam int ADDR_W   = 8;
  localparam int CNT_W    = 10;
  localparam int NUM_BANK = 2;
  localparam int BANK_W   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, cfg_reg_mode, sw_aen, req_valid, req_pgm, req_rd, req_force;
  logic [CNT_W-1:0]    cfg_tpgm, cfg_trd, cfg_tgap;
  logic [BANK_W-1:0]   sw_bank, req_bank;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_ready, done_pulse, done_sts, err_sts, skip_sts, busy;
  logic [NUM_BANK-1:0] efuse_aen;
  logic [ADDR_W-1:0]   efuse_addr;

  efuse_aen_pulse_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_BANK(NUM_BANK)) dut (
    .clk(clk), .rst(rst), .cfg_reg_mode(cfg_reg_mode), .cfg_tpgm(cfg_tpgm), .cfg_trd(cfg_trd),
    .cfg_tgap(cfg_tgap), .sw_aen(sw_aen), .sw_bank(sw_bank), .req_valid(req_valid),
    .req_ready(req_ready), .req_pgm(req_pgm), .req_rd(req_rd), .req_force(req_force),
    .req_bank(req_bank), .req_addr(req_addr), .efuse_aen(efuse_aen), .efuse_addr(efuse_addr),
    .done_pulse(done_pulse), .done_sts(done_sts), .err_sts(err_sts), .skip_sts(skip_sts),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference model: one in-flight op described by its accept cycle, gap, width and bank.
  bit                  act;
  int                  p_t0, p_g, p_w;
  int                  p_bank;
  int                  done_at = -1;
  bit                  lv, l_pgm;
  logic [BANK_W-1:0]   l_bank;
  logic [ADDR_W-1:0]   l_addr, m_addr;
  bit                  m_err, m_skip, m_done, ds_known;
  logic [NUM_BANK-1:0] man_aen;
  bit                  acc_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, t);
    end
  endtask

  function automatic logic [NUM_BANK-1:0] onehot(input int b);
    return NUM_BANK'(1) << b;
  endfunction

  function automatic logic [NUM_BANK-1:0] exp_aen();
    if (act && t >= p_t0 + p_g + 1 && t <= p_t0 + p_g + p_w) return onehot(p_bank);
    return man_aen;
  endfunction

  function automatic bit exp_ready();
    return cfg_reg_mode && !act && (t != done_at);
  endfunction

  task automatic model_edge();
    int tn;
    int w;
    bit rdy;
    tn = t + 1;
    rdy = exp_ready();
    acc_last = 1'b0;
    if (rst) begin
      act = 0; done_at = -1; lv = 0; m_err = 0; m_skip = 0; m_done = 0; ds_known = 1;
      m_addr = '0; man_aen = '0;
    end else if (!cfg_reg_mode) begin
      man_aen = (!act && sw_aen) ? onehot(int'(sw_bank)) : '0;
      act = 0;
      lv  = 0;
    end else begin
      man_aen = '0;
      if (act && tn == p_t0 + 2 * p_g + p_w + 1) begin
        act = 0; done_at = tn; m_done = 1;
      end
      if (rdy && req_valid) begin
        acc_last = 1'b1;
        m_addr   = req_addr;
        if (req_pgm == req_rd) begin
          m_err = 1; m_skip = 0; lv = 0; done_at = tn; m_done = 1; ds_known = 0;
        end else if (lv && !req_force && req_bank == l_bank && req_addr == l_addr &&
                     req_pgm == l_pgm) begin
          m_err = 0; m_skip = 1; done_at = tn; m_done = 1; ds_known = 0;
        end else begin
          m_err = 0; m_skip = 0; m_done = 0; ds_known = 1;
          lv = 1; l_bank = req_bank; l_addr = req_addr; l_pgm = req_pgm;
          w = req_pgm ? int'(cfg_tpgm) : int'(cfg_trd);
          act = 1; p_t0 = tn; p_g = int'(cfg_tgap); p_w = (w == 0) ? 1 : w;
          p_bank = int'(req_bank);
        end
      end
    end
    t = tn;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("efuse_aen",  32'(efuse_aen),  32'(exp_aen()));
    check("done_pulse", 32'(done_pulse), 32'(t == done_at));
    check("busy",       32'(busy),       32'(act));
    check("req_ready",  32'(req_ready),  32'(exp_ready()));
    check("err_sts",    32'(err_sts),    32'(m_err));
    check("efuse_addr", 32'(efuse_addr), 32'(m_addr));
    if (!act)     check("skip_sts", 32'(skip_sts), 32'(m_skip));
    if (ds_known) check("done_sts", 32'(done_sts), 32'(m_done));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input bit pgm, input bit rd, input bit frc, input int bank, input int addr);
    req_valid = 1'b1; req_pgm = pgm; req_rd = rd; req_force = frc;
    req_bank = BANK_W'(bank); req_addr = ADDR_W'(addr);
    acc_last = 1'b0;
    for (int i = 0; i < 3000 && !acc_last; i++) cycle();
    check("accept_seen", 32'(acc_last), 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_reg_mode = 1'b1; cfg_tpgm = 10'd5; cfg_trd = 10'd3; cfg_tgap = 10'd2;
    sw_aen = 1'b0; sw_bank = '0; req_valid = 1'b0; req_pgm = 1'b0; req_rd = 1'b0;
    req_force = 1'b0; req_bank = '0; req_addr = '0;
    run(3);
    check("reset_aen",  32'(efuse_aen),  32'd0);
    check("reset_addr", 32'(efuse_addr), 32'd0);
    rst = 1'b0;
    run(2);

    // Program, gap 2, width 5 on bank 1.
    send(1, 0, 0, 1, 'h12);
    run(14);

    // Repeated read to the same target: second one is skipped, then forced.
    cfg_tgap = 10'd0; cfg_trd = 10'd3;
    send(0, 1, 0, 0, 'h12);
    run(6);
    send(0, 1, 0, 0, 'h12);
    run(3);
    check("skip_after_repeat", 32'(skip_sts), 32'd1);
    send(0, 1, 1, 0, 'h12);
    run(6);
    check("skip_after_force", 32'(skip_sts), 32'd0);

    // Illegal op, then a legal op clears the error.
    send(1, 1, 0, 0, 'h55);
    check("err_set", 32'(err_sts), 32'd1);
    run(2);
    send(1, 0, 0, 0, 'h56);
    run(8);
    check("err_cleared", 32'(err_sts), 32'd0);

    // Zero width is one cycle.
    cfg_tpgm = 10'd0;
    send(1, 0, 0, 1, 'h60);
    run(4);

    // Drop to bypass mid-pulse.
    cfg_tpgm = 10'd8;
    send(1, 0, 0, 0, 'h61);
    run(3);
    cfg_reg_mode = 1'b0;
    cycle();
    check("abort_aen", 32'(efuse_aen), 32'd0);
    run(2);
    cfg_reg_mode = 1'b1;
    run(2);

    // Reset mid-pulse.
    send(1, 0, 0, 1, 'h62);
    run(3);
    rst = 1'b1;
    cycle();
    check("rst_mid_aen",  32'(efuse_aen), 32'd0);
    check("rst_mid_busy", 32'(busy),      32'd0);
    rst = 1'b0;
    run(2);

    // Manual bypass.
    cfg_reg_mode = 1'b0; sw_aen = 1'b1; sw_bank = 1'b1; req_valid = 1'b1;
    cycle();
    check("manual_aen",   32'(efuse_aen), 32'd2);
    check("manual_ready", 32'(req_ready), 32'd0);
    run(3);
    req_valid = 1'b0; sw_aen = 1'b0;
    run(2);
    cfg_reg_mode = 1'b1;
    run(2);

    // All-ones width: 1023 cycles of AEN.
    cfg_tgap = 10'd0; cfg_tpgm = '1;
    send(1, 0, 0, 0, 'h70);
    run(1030);

    // Random traffic; config keeps changing to confirm it is latched at accept.
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst = ($urandom_range(0, 499) == 0);
      if (cfg_reg_mode) cfg_reg_mode = ($urandom_range(0, 149) != 0);
      else              cfg_reg_mode = ($urandom_range(0, 5) == 0);
      cfg_tpgm  = CNT_W'($urandom_range(0, 4));
      cfg_trd   = CNT_W'($urandom_range(0, 4));
      cfg_tgap  = CNT_W'($urandom_range(0, 3));
      sw_aen    = 1'($urandom_range(0, 1));
      sw_bank   = BANK_W'($urandom_range(0, NUM_BANK - 1));
      req_valid = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      req_pgm   = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : r[0];
      req_rd    = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : ~r[0];
      req_force = ($urandom_range(0, 3) == 0);
      req_bank  = BANK_W'($urandom_range(0, NUM_BANK - 1));
      req_addr  = ($urandom_range(0, 1) == 0) ? ADDR_W'('h12) : ADDR_W'('h34);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
